// File: rtl/counter_ctrl.sv
// Push-button sequencer: sync, debounce FSM, switch capture, event count.
// COUNTER_CTRL_AUTOREPEAT_EN adds periodic strobes while the key is held.
module counter_ctrl #(
   parameter int DATA_W       = 10,
   parameter int CNT_W        = 8,
   parameter int DEBOUNCE_CYC = 4,
   parameter int REPEAT_CYC   = 16
) (
   input  logic              clk100_i,
   input  logic              rst_i,
   input  logic              key_n_i,
   input  logic [DATA_W-1:0] sw_i,
   input  logic              clr_i,
   output logic [DATA_W-1:0] data_o,
   output logic              we_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic              busy_o,
   output logic [1:0]        state_o
);

   localparam int DBC_W =
      (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DBC_W-1:0] DBC_MAX =
      DBC_W'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              key_m;
   logic              key_s;
   logic [DBC_W-1:0]  dbc;
   logic [DBC_W-1:0]  dbc_nxt;
   logic              strobe;
   logic [DATA_W-1:0] data_q;
   logic              we_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;

`ifdef COUNTER_CTRL_AUTOREPEAT_EN
   localparam int RPT_W = $clog2(REPEAT_CYC);
   localparam logic [RPT_W-1:0] RPT_MAX =
      RPT_W'(REPEAT_CYC - 1);

   logic [RPT_W-1:0]  rpt;
   logic [RPT_W-1:0]  rpt_nxt;
`endif

   always_comb begin
      state_nxt = state;
      dbc_nxt   = dbc;
      strobe    = 1'b0;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
      // Zero unless held in PRESSED, so every entry restarts the period.
      rpt_nxt   = '0;
`endif
      unique case (state)
         IDLE: begin
            if (!key_s) begin
               state_nxt = DEB_PRESS;
               dbc_nxt   = '0;
            end
         end
         DEB_PRESS: begin
            if (key_s) begin
               state_nxt = IDLE;
            end else if (dbc == DBC_MAX) begin
               state_nxt = PRESSED;
               strobe    = 1'b1;
            end else begin
               dbc_nxt = dbc + 1'b1;
            end
         end
         PRESSED: begin
            if (key_s) begin
               state_nxt = DEB_RELEASE;
               dbc_nxt   = '0;
            end
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
            else if (rpt == RPT_MAX) begin
               strobe = 1'b1;
            end else begin
               rpt_nxt = rpt + 1'b1;
            end
`endif
         end
         DEB_RELEASE: begin
            if (!key_s) begin
               state_nxt = PRESSED;
            end else if (dbc == DBC_MAX) begin
               state_nxt = IDLE;
            end else begin
               dbc_nxt = dbc + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Sync flops reset to released so reset never fakes a press.
   always_ff @(posedge clk100_i) begin
      if (rst_i) begin
         key_m  <= 1'b1;
         key_s  <= 1'b1;
         state  <= IDLE;
         dbc    <= '0;
         data_q <= '0;
         we_q   <= 1'b0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
         rpt    <= '0;
`endif
      end else begin
         key_m  <= key_n_i;
         key_s  <= key_m;
         state  <= state_nxt;
         dbc    <= dbc_nxt;
         we_q   <= strobe;
         busy_q <= (state_nxt != IDLE);
`ifdef COUNTER_CTRL_AUTOREPEAT_EN
         rpt    <= rpt_nxt;
`endif
         if (strobe) begin
            data_q <= sw_i;
         end
         if (clr_i) begin
            cnt_q <= '0;
         end else if (strobe) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign data_o  = data_q;
   assign we_o    = we_q;
   assign cnt_o   = cnt_q;
   assign busy_o  = busy_q;
   assign state_o = state;

endmodule
